// File: rtl/present_ctrl.sv
// PRESENT-80 encryption controller: one round datapath iterated over 31 cycles.
// Optional PRESENT_CTRL_ABORT_EN: dropping req during RUN abandons the operation.

package present_pkg;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] s;
    s = 4'h0;
    case (n)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      4'hF: s = 4'h2;
      default: s = 4'h0;
    endcase
    return s;
  endfunction

  function automatic logic [79:0] ks(
    input logic [79:0] key,
    input logic [4:0]  i
  );
    logic [79:0] t;
    t = {key[18:0], key[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ i;
    return t;
  endfunction

endpackage

module present_round
  import present_pkg::*;
(
  input  logic [63:0] x_i,
  input  logic [79:0] k_i,
  output logic [63:0] r_o
);

  logic [63:0] ark;
  logic [63:0] sb;

  always_comb begin
    ark = x_i ^ k_i[79:16];
    sb  = '0;
    for (int n = 0; n < 16; n++) begin
      sb[4*n +: 4] = sbox(ark[4*n +: 4]);
    end
  end

  // Bit permutation: input bit 4n+q lands on output bit 16q+n.
  always_comb begin
    r_o = '0;
    for (int q = 0; q < 4; q++) begin
      for (int n = 0; n < 16; n++) begin
        r_o[16*q + n] = sb[4*n + q];
      end
    end
  end

endmodule

module present_ctrl
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ack,
  input  logic [63:0] x,
  input  logic [79:0] k,
  output logic [63:0] r,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } st_t;

  st_t         st_q, st_d;
  logic [63:0] s_q, s_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] r_q, r_d;

  logic [63:0] rnd;
  logic [79:0] ks_k;

  present_round u_round (
    .x_i (s_q),
    .k_i (key_q),
    .r_o (rnd)
  );

  assign ks_k = ks(key_q, cnt_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      s_q   <= '0;
      key_q <= '0;
      cnt_q <= '0;
      r_q   <= '0;
    end else begin
      st_q  <= st_d;
      s_q   <= s_d;
      key_q <= key_d;
      cnt_q <= cnt_d;
      r_q   <= r_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    s_d   = s_q;
    key_d = key_q;
    cnt_d = cnt_q;
    r_d   = r_q;
    case (st_q)
      IDLE: begin
        if (req) begin
          s_d   = x;
          key_d = k;
          cnt_d = 5'd1;
          st_d  = RUN;
        end
      end
      RUN: begin
`ifdef PRESENT_CTRL_ABORT_EN
        if (!req) begin
          st_d = IDLE;
        end else begin
`else
        begin
`endif
          // Last round folds in the final whitening key K32.
          if (cnt_q == 5'd31) begin
            r_d  = rnd ^ ks_k[79:16];
            st_d = DONE;
          end else begin
            s_d   = rnd;
            key_d = ks_k;
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      DONE: begin
        if (!req) begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign ack  = (st_q == DONE);
  assign busy = (st_q == RUN);
  assign r    = r_q;

endmodule

// File: tb/tb_present_ctrl.sv
// Directed bench for present_ctrl: known PRESENT-80 vectors, handshake,
// latency, reset-abandon and input-isolation checks via a result queue.
`timescale 1ns/1ps
module tb_present_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        ack;
  logic [63:0] x;
  logic [79:0] k;
  logic [63:0] r;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = {80{1'b1}};
  localparam logic [63:0] X0 = 64'h0;
  localparam logic [63:0] X1 = {64{1'b1}};

  present_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .ack  (ack),
    .x    (x),
    .k    (k),
    .r    (r),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [79:0] obs,
    input logic [79:0] expv
  );
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Load, count busy/latency until ack, then compare against the queue head.
  task automatic run(
    input string       tag,
    input logic [63:0] xv,
    input logic [79:0] kv,
    input logic [63:0] ev,
    input int          drop_at,
    input bit          scramble
  );
    int lat;
    int bcnt;
    logic [63:0] e;
    @(negedge clk);
    x   = xv;
    k   = kv;
    req = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk);
    lat  = 0;
    bcnt = 0;
    while (lat < 64) begin
      @(negedge clk);
      if (ack) break;
      if (busy) bcnt++;
      if (lat == drop_at) req = 1'b0;
      if (scramble) begin
        x = {$urandom, $urandom};
        k = {$urandom, $urandom, 16'($urandom)};
      end
      @(posedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 80'(lat), 80'd31);
    chk({tag, "_busycnt"}, 80'(bcnt), 80'd31);
    chk({tag, "_busy_at_ack"}, 80'(busy), 80'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 80'd1, 80'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_r"}, 80'(r), 80'(e));
    end
  endtask

  task automatic release_req(input string tag);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ack_drop"}, 80'(ack), 80'd0);
    chk({tag, "_idle_busy"}, 80'(busy), 80'd0);
  endtask

  initial begin
    int bad;
    int seen;
    logic [63:0] prev;

    rst_n = 1'b0;
    req   = 1'b0;
    x     = X1;
    k     = K1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 80'(ack), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_r", 80'(r), 80'd0);
    rst_n = 1'b1;

    run("v00", X0, K0, 64'h5579C1387B228445, -1, 1'b0);
    release_req("v00");

    run("v0f", X0, K1, 64'hE72C46C0F5945049, -1, 1'b0);
    release_req("v0f");

    run("vff", X1, K1, 64'h3333DCD3213210D2, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      x = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      if (ack !== 1'b1 || busy !== 1'b0 || r !== 64'h3333DCD3213210D2) bad++;
    end
    chk("hold_ack_stable", 80'(bad), 80'd0);
    release_req("vff");
    @(posedge clk);
    @(negedge clk);
    chk("no_reload_busy", 80'(busy), 80'd0);
    chk("no_reload_r", 80'(r), 80'h3333DCD3213210D2);

    @(negedge clk);
    x   = X1;
    k   = K0;
    req = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 80'(busy), 80'd1);
    rst_n = 1'b0;
    req   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ack", 80'(ack), 80'd0);
    chk("mid_rst_r", 80'(r), 80'd0);
    chk("mid_rst_busy", 80'(busy), 80'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ack || busy) seen++;
    end
    chk("no_ack_after_rst", 80'(seen), 80'd0);
    run("vf0", X1, K0, 64'hA112FFC72F68417B, -1, 1'b0);
    release_req("vf0");

`ifdef PRESENT_CTRL_ABORT_EN
    prev = r;
    @(negedge clk);
    x   = X0;
    k   = K1;
    req = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_idle", 80'(busy), 80'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ack) seen++;
    end
    chk("abort_no_ack", 80'(seen), 80'd0);
    chk("abort_r_kept", 80'(r), 80'(prev));
`else
    run("drop", X0, K1, 64'hE72C46C0F5945049, 5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("drop_ack_fall", 80'(ack), 80'd0);
    chk("drop_idle_busy", 80'(busy), 80'd0);
`endif

    run("scr", X0, K0, 64'h5579C1387B228445, -1, 1'b1);
    release_req("scr");
    chk("scr_r_kept", 80'(r), 80'h5579C1387B228445);

    chk("queue_drained", 80'(exp_q.size()), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/present_ctrl.md
PRESENT_CTRL -- requirements
Module: present_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-003 req  input  1  request; high with x and k stable starts an encryption (4-phase handshake).
REQ-004 ack  output  1  acknowledge; high means r valid; drops only after req sampled low.
REQ-005 x  input  64  plaintext; sampled only on the load edge.
REQ-006 k  input  80  cipher key; sampled only on the load edge.
REQ-007 r  output  64  ciphertext register; stable from ack rise until next load edge.
REQ-008 busy  output  1  high in RUN state only.

Function
REQ-009 Block SHALL instantiate existing round module once (64-bit x, 80-bit k in, 64-bit r out) and iterate it; no second round instance.
REQ-010 FSM states SHALL be IDLE, RUN, DONE; encoding free; no other reachable states.
REQ-011 IDLE: rising edge with req=1 SHALL latch state<=x, key<=k, cnt<=1, go RUN (load edge).
REQ-012 RUN, cnt<31: each edge SHALL do state<=round(state,key), key<=ks(key,cnt), cnt<=cnt+1.
REQ-013 RUN, cnt==31: edge SHALL do r<=round(state,key) XOR ks(key,31)[79:16], go DONE; state/key/cnt don't-care afterward.
REQ-014 ks(key,i) SHALL be: rotate left 61; key[79:76]<=Sbox(key[79:76]); key[19:15]<=key[19:15] XOR i[4:0]; PRESENT S-box.
REQ-015 cnt SHALL be 5 bits, values 1..31, never wraps inside RUN.
REQ-016 Latency: ack SHALL rise exactly 31 clk cycles after load edge; busy high for those 31 cycles.
REQ-017 DONE: ack=1; edge with req=0 SHALL go IDLE with ack<=0; req held high keeps DONE indefinitely.
REQ-018 IDLE with req=0 SHALL hold all registers; r unchanged.
REQ-019 req dropped during RUN SHALL be ignored (default build); result still completes to DONE, then leaves DONE on first edge with req=0.
REQ-020 x, k changes outside load edge SHALL NOT affect r.
REQ-021 Back-to-back: req must be seen low in DONE before a new load; a new load SHALL need a separate IDLE-with-req=1 edge.

Reset
REQ-022 rst_n=0 at edge SHALL force IDLE, ack=0, busy=0, r=0, cnt=0, state=0, key=0; priority over all other events.
REQ-023 Reset during RUN or DONE SHALL abandon the operation; no ack pulse afterward.
REQ-024 After rst_n rises, req already high SHALL be treated as new request on first edge in IDLE.

Configuration
REQ-025 Macro PRESENT_CTRL_ABORT_EN defined: req sampled low in RUN SHALL go IDLE next edge, ack stays 0, r keeps previous value.
REQ-026 Macro undefined: behaviour per REQ-019; abort logic absent from netlist.

Verification
REQ-027 x=0000000000000000, k=00000000000000000000 -> ack after 31 cycles, r=5579C1387B228445.
REQ-028 x=0000000000000000, k=FFFFFFFFFFFFFFFFFFFF -> r=E72C46C0F5945049; busy high exactly 31 cycles.
REQ-029 x=FFFFFFFFFFFFFFFF, k=FFFFFFFFFFFFFFFFFFFF, req held high 100 cycles -> r=3333DCD3213210D2, ack held until req low, then ack=0 next edge, no reload.
REQ-030 x=FFFFFFFFFFFFFFFF, k=0, rst_n pulsed low at cycle 10 of RUN -> ack=0, r=0; rerun -> r=A112FFC72F68417B.
REQ-031 Default build, req dropped at RUN cycle 5 -> ack still rises at cycle 31 with correct r; ABORT_EN build -> IDLE next edge, ack never rises, r unchanged.
REQ-032 Change x,k every cycle during RUN after load of x=0,k=0 -> r=5579C1387B228445.
